tile_gatherer: RTL

Converts a raster-order 8-bit grayscale pixel stream into 8×8 tiles packed as 512-bit vectors for the tile statistics stages (mean/variance). Eight image rows are held in a strip buffer. Each time the last pixel of a tile arrives, the tile is gathered into an output register and presented with a valid/ready handshake. The block sits between the camera/pixel front end and the statistics units.

---
 rtl/tile_gatherer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tile_gatherer.sv
// tile_gatherer: raster pixel stream -> 8x8 tiles packed as 512-bit words.
// Optional `TILE_POS_EN adds tile_x/tile_y position outputs.
module tile_gatherer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   pix,
  input  logic         pix_valid,
  input  logic         pix_sof,
  output logic         pix_ready,
  output logic [511:0] tile,
  output logic         tile_valid,
  input  logic         tile_ready
`ifdef TILE_POS_EN
  ,
  output logic [6:0]   tile_x,
  output logic [6:0]   tile_y
`endif
);

  localparam int CW = ($clog2(IMG_WIDTH) < 4) ? 4 : $clog2(IMG_WIDTH);
  localparam int RW = ($clog2(IMG_HEIGHT) < 4) ? 4 : $clog2(IMG_HEIGHT);
  localparam int KW = CW - 3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_GATHER = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [KW-1:0] r_k;
  logic [2:0]    r_gcnt;
  logic [511:0]  r_tile;
  logic          r_tile_valid;
  logic          r_pix_ready;
  logic [7:0]    r_buf [8][IMG_WIDTH];
`ifdef TILE_POS_EN
  logic [6:0]    r_tile_x;
  logic [6:0]    r_tile_y;
`endif

  logic          w_acc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_done;
  logic [63:0]   w_line;

  // pix_ready is only ever high in FILL, so it alone qualifies acceptance
  assign w_acc  = pix_valid && r_pix_ready;
  assign w_col  = pix_sof ? '0 : r_col;
  assign w_row  = pix_sof ? '0 : r_row;
  assign w_done = (w_row[2:0] == 3'd7) && (w_col[2:0] == 3'd7);

  always_comb begin
    w_line = '0;
    for (int c = 0; c < 8; c++) begin
      w_line[8*c +: 8] = r_buf[r_gcnt][{r_k, 3'(c)}];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_buf[w_row[2:0]][w_col] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_col        <= '0;
      r_row        <= '0;
      r_k          <= '0;
      r_gcnt       <= '0;
      r_tile       <= '0;
      r_tile_valid <= 1'b0;
      r_pix_ready  <= 1'b0;
`ifdef TILE_POS_EN
      r_tile_x     <= '0;
      r_tile_y     <= '0;
`endif
    end else begin
      if (w_acc) begin
        if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
      case (r_state)
        S_FILL: begin
          r_pix_ready <= 1'b1;
          if (w_acc && w_done) begin
            r_pix_ready <= 1'b0;
            r_k         <= w_col[CW-1:3];
            r_gcnt      <= '0;
            r_state     <= S_GATHER;
`ifdef TILE_POS_EN
            r_tile_x    <= 7'(w_col[CW-1:3]);
            r_tile_y    <= 7'(w_row[RW-1:3]);
`endif
          end
        end
        S_GATHER: begin
          r_tile[{r_gcnt, 6'd0} +: 64] <= w_line;
          r_gcnt <= r_gcnt + 3'd1;
          if (r_gcnt == 3'd7) begin
            r_tile_valid <= 1'b1;
            r_state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tile_ready) begin
            r_tile_valid <= 1'b0;
            r_pix_ready  <= 1'b1;
            r_state      <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign pix_ready  = r_pix_ready;
  assign tile       = r_tile;
  assign tile_valid = r_tile_valid;
`ifdef TILE_POS_EN
  assign tile_x     = r_tile_x;
  assign tile_y     = r_tile_y;
`endif

endmodule
